// File: rtl/simon_key_schedule.sv
// Simon 64/128 round-key generator: expands a 128-bit master key in a 4-word sliding window,
// emitting one 32-bit round key per valid/ready transfer.
module simon_key_schedule #(
  parameter int ROUNDS = 44
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [31:0]  round_key,
  output logic [5:0]   round_idx,
  output logic         last
);

  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [5:0]  LAST_IDX = 6'(ROUNDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [31:0] w0, w1, w2, w3;
  logic [5:0]  zidx;

  logic [31:0] rot3, t1, t2, knew;
  logic        zbit, xfer;

  // z3 is written MSB-first, so character j lives at bit 61-j
  assign zbit = Z3[6'd61 - zidx];
  assign rot3 = {w3[2:0], w3[31:3]};
  assign t1   = rot3 ^ w1;
  assign t2   = t1 ^ {t1[0], t1[31:1]};
  assign knew = 32'hFFFF_FFFC ^ {31'd0, zbit} ^ w0 ^ t2;
  assign xfer = rk_valid & rk_ready;

  assign round_key = w0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rk_valid  <= 1'b0;
      last      <= 1'b0;
      round_idx <= 6'd0;
      zidx      <= 6'd0;
      w0        <= 32'd0;
      w1        <= 32'd0;
      w2        <= 32'd0;
      w3        <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            w0        <= key[31:0];
            w1        <= key[63:32];
            w2        <= key[95:64];
            w3        <= key[127:96];
            round_idx <= 6'd0;
            zidx      <= 6'd0;
            busy      <= 1'b1;
            rk_valid  <= 1'b1;
            last      <= (LAST_IDX == 6'd0);
          end
        end
        RUN: begin
          if (xfer) begin
            w0        <= w1;
            w1        <= w2;
            w2        <= w3;
            w3        <= knew;
            round_idx <= round_idx + 6'd1;
            zidx      <= (zidx == 6'd61) ? 6'd0 : zidx + 6'd1;
            if (last) begin
              state    <= IDLE;
              busy     <= 1'b0;
              rk_valid <= 1'b0;
              last     <= 1'b0;
            end else begin
              last <= ((round_idx + 6'd1) == LAST_IDX);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_key_schedule.sv
// Directed bench for simon_key_schedule: standard Simon 64/128 vector, backpressure,
// ignored start, mid-run reset and back-to-back runs.
module tb_simon_key_schedule;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [31:0]  round_key;
  logic [5:0]   round_idx;
  logic         last;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] K1 = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [127:0] K2 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] KA = 128'hdeadbeef_cafef00d_01234567_89abcdef;

  logic [61:0] zc;
  logic [31:0] gold  [0:43];
  logic [31:0] gold2 [0:43];
  logic [31:0] got   [0:43];

  simon_key_schedule #(.ROUNDS(44)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .key       (key),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .last      (last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] v, input int s);
    return (v >> s) | (v << (32 - s));
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  // Reference expansion written as the textbook recurrence over a flat key array
  task automatic gen_gold(input logic [127:0] k, input bit second);
    logic [31:0] kk [0:43];
    logic [31:0] t;
    kk[0] = k[31:0];
    kk[1] = k[63:32];
    kk[2] = k[95:64];
    kk[3] = k[127:96];
    for (int i = 0; i < 40; i++) begin
      t = ror(kk[i+3], 3) ^ kk[i+1];
      t = t ^ ror(t, 1);
      kk[i+4] = 32'hFFFF_FFFC ^ {31'd0, zc[61-i]} ^ kk[i] ^ t;
    end
    for (int i = 0; i < 44; i++) begin
      if (second) gold2[i] = kk[i];
      else        gold[i]  = kk[i];
    end
  endtask

  task automatic do_start(input logic [127:0] k);
    @(negedge clk);
    start = 1'b1;
    key   = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; rk_ready = 1'b0; key = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rk_valid); end
    n_checks++; if (last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", last); end
    n_checks++; if (round_idx !== 6'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", round_idx); end
    n_checks++; if (round_key !== 32'd0) begin n_fail++; $display("FAIL reset_key: got %h want 0", round_key); end
  endtask

  task automatic test_standard;
    int n, cyc;
    logic [31:0] x, y, tmp;
    do_start(K1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b want 1", busy); end
    n_checks++; if (rk_valid !== 1'b1) begin n_fail++; $display("FAIL start_valid: got %b want 1", rk_valid); end
    rk_ready = 1'b1; n = 0; cyc = 0;
    while (n < 44 && cyc < 200) begin
      if (rk_valid) begin
        got[n] = round_key;
        n_checks++; if (round_key !== gold[n]) begin n_fail++; $display("FAIL std_key[%0d]: got %h want %h", n, round_key, gold[n]); end
        n_checks++; if (round_idx !== 6'(n)) begin n_fail++; $display("FAIL std_idx: got %0d want %0d", round_idx, n); end
        n_checks++; if (last !== (n == 43)) begin n_fail++; $display("FAIL std_last[%0d]: got %b", n, last); end
        n++;
      end
      @(negedge clk); cyc++;
    end
    n_checks++; if (cyc !== 44) begin n_fail++; $display("FAIL std_cycles: got %0d want 44", cyc); end
    n_checks++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL std_end_valid: got %b want 0", rk_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL std_end_busy: got %b want 0", busy); end
    n_checks++; if (last !== 1'b0) begin n_fail++; $display("FAIL std_end_last: got %b want 0", last); end
    n_checks++; if (got[0] !== 32'h03020100) begin n_fail++; $display("FAIL std_k0: got %h want 03020100", got[0]); end
    n_checks++; if (got[1] !== 32'h0b0a0908) begin n_fail++; $display("FAIL std_k1: got %h want 0b0a0908", got[1]); end
    n_checks++; if (got[2] !== 32'h13121110) begin n_fail++; $display("FAIL std_k2: got %h want 13121110", got[2]); end
    n_checks++; if (got[3] !== 32'h1b1a1918) begin n_fail++; $display("FAIL std_k3: got %h want 1b1a1918", got[3]); end
    n_checks++; if (got[4] !== 32'h70a011c3) begin n_fail++; $display("FAIL std_k4: got %h want 70a011c3", got[4]); end
    // Encrypt the published plaintext with the keys the DUT actually delivered
    x = 32'h656b696c; y = 32'h20646e75;
    for (int i = 0; i < 44; i++) begin
      tmp = x;
      x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ got[i];
      y = tmp;
    end
    n_checks++; if ({x, y} !== 64'h44c8fc20_b9dfa07a) begin n_fail++; $display("FAIL std_cipher: got %h want 44c8fc20b9dfa07a", {x, y}); end
  endtask

  task automatic test_backpressure;
    int n, cyc, extra;
    logic r, stalled;
    logic [31:0] pk;
    logic [5:0]  pi;
    do_start(K1);
    n = 0; cyc = 0; stalled = 1'b0; pk = '0; pi = '0;
    while (n < 44 && cyc < 2000) begin
      r = ($urandom_range(0, 9) < 3);
      if (stalled) begin
        n_checks++; if (rk_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 1", rk_valid); end
        n_checks++; if (round_key !== pk) begin n_fail++; $display("FAIL bp_key_hold: got %h want %h", round_key, pk); end
        n_checks++; if (round_idx !== pi) begin n_fail++; $display("FAIL bp_idx_hold: got %0d want %0d", round_idx, pi); end
      end
      if (rk_valid) begin
        if (r) begin
          n_checks++; if (round_key !== gold[n]) begin n_fail++; $display("FAIL bp_key[%0d]: got %h want %h", n, round_key, gold[n]); end
          n_checks++; if (round_idx !== 6'(n)) begin n_fail++; $display("FAIL bp_idx: got %0d want %0d", round_idx, n); end
          n++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; pk = round_key; pi = round_idx;
        end
      end
      rk_ready = r;
      @(negedge clk); cyc++;
    end
    n_checks++; if (n !== 44) begin n_fail++; $display("FAIL bp_count: got %0d want 44", n); end
    rk_ready = 1'b1; extra = 0;
    repeat (5) begin
      if (rk_valid) extra++;
      @(negedge clk);
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL bp_extra: got %0d extra words want 0", extra); end
  endtask

  task automatic test_start_ignored;
    int n, cyc;
    bit pulsed;
    do_start(K1);
    rk_ready = 1'b1; n = 0; cyc = 0; pulsed = 1'b0;
    while (n < 44 && cyc < 200) begin
      start = 1'b0;
      if (rk_valid) begin
        n_checks++; if (round_key !== gold[n]) begin n_fail++; $display("FAIL ign_key[%0d]: got %h want %h", n, round_key, gold[n]); end
        if (round_idx == 6'd10 && !pulsed) begin start = 1'b1; key = KA; pulsed = 1'b1; end
        n++;
      end
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    n_checks++; if (n !== 44 || !pulsed) begin n_fail++; $display("FAIL ign_count: got %0d want 44", n); end
    n_checks++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL ign_end_valid: got %b want 0", rk_valid); end
  endtask

  task automatic test_reset_midrun;
    int n, cyc;
    do_start(K1);
    rk_ready = 1'b1; cyc = 0;
    while (!(rk_valid && round_idx == 6'd20) && cyc < 100) begin @(negedge clk); cyc++; end
    n_checks++; if (round_idx !== 6'd20) begin n_fail++; $display("FAIL rst_reach: got %0d want 20", round_idx); end
    rstn = 1'b0;
    @(negedge clk);
    n_checks++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", rk_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (round_key !== 32'd0) begin n_fail++; $display("FAIL rst_key: got %h want 0", round_key); end
    n_checks++; if (round_idx !== 6'd0) begin n_fail++; $display("FAIL rst_idx: got %0d want 0", round_idx); end
    rstn = 1'b1;
    do_start(K1);
    n = 0; cyc = 0;
    while (n < 44 && cyc < 200) begin
      if (rk_valid) begin
        n_checks++; if (round_key !== gold[n]) begin n_fail++; $display("FAIL rst_key[%0d]: got %h want %h", n, round_key, gold[n]); end
        n_checks++; if (round_idx !== 6'(n)) begin n_fail++; $display("FAIL rst_idx2: got %0d want %0d", round_idx, n); end
        n++;
      end
      @(negedge clk); cyc++;
    end
    n_checks++; if (n !== 44) begin n_fail++; $display("FAIL rst_count: got %0d want 44", n); end
  endtask

  task automatic test_back_to_back;
    int n, cyc;
    do_start(K1);
    rk_ready = 1'b1; cyc = 0;
    while (!(rk_valid && last) && cyc < 100) begin @(negedge clk); cyc++; end
    n_checks++; if (round_idx !== 6'd43) begin n_fail++; $display("FAIL b2b_last_idx: got %0d want 43", round_idx); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_busy: got %b want 0", busy); end
    start = 1'b1; key = K2;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (rk_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", rk_valid); end
    n_checks++; if (round_idx !== 6'd0) begin n_fail++; $display("FAIL b2b_idx0: got %0d want 0", round_idx); end
    n = 0; cyc = 0;
    while (n < 44 && cyc < 200) begin
      if (rk_valid) begin
        n_checks++; if (round_key !== gold2[n]) begin n_fail++; $display("FAIL b2b_key[%0d]: got %h want %h", n, round_key, gold2[n]); end
        n_checks++; if (last !== (n == 43)) begin n_fail++; $display("FAIL b2b_last[%0d]: got %b", n, last); end
        n++;
      end
      @(negedge clk); cyc++;
    end
    n_checks++; if (n !== 44) begin n_fail++; $display("FAIL b2b_count: got %0d want 44", n); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy: got %b want 0", busy); end
  endtask

  initial begin
    zc = 62'b11011011101011000110010111100000010010001010011100110100001111;
    gen_gold(K1, 1'b0);
    gen_gold(K2, 1'b1);
    test_reset();
    test_standard();
    test_backpressure();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
